// File: rtl/attack_history.sv
// Sticky attack-history map: each debounced button press commits a bulk merge
// or a single-cell write, with a population count and full indication.
module attack_history #(
  parameter  int ROWS  = 7,
  parameter  int COLS  = 5,
  localparam int N     = ROWS * COLS,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             enable,
  input  logic             mode,
  input  logic [N-1:0]     map_in,
  input  logic [RW-1:0]    row_sel,
  input  logic [CW-1:0]    col_sel,
  output logic [N-1:0]     map_out,
  output logic [CNT_W-1:0] hit_count,
  output logic             full,
  output logic             commit_ack,
  output logic             repeat_flag,
  output logic             invalid_addr
);

  typedef enum logic {IDLE = 1'b0, WAIT_RELEASE = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         r_btn_q;
  logic         w_rise;
  logic         w_accept;
  logic         w_in_range;
  logic         w_repeat;
  logic         w_invalid;
  logic [N-1:0] w_mask;
  logic [N-1:0] w_map_next;
  int           w_idx;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  assign w_rise   = btn & ~r_btn_q;
  assign w_accept = (r_state == IDLE) & w_rise & enable;

  // Holding the button after an accepted commit must not re-trigger.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = WAIT_RELEASE;
        else          w_state_next = IDLE;
      end
      WAIT_RELEASE: begin
        if (!btn) w_state_next = IDLE;
        else      w_state_next = WAIT_RELEASE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Candidate map for a commit; bits are only ever OR-ed in.
  always_comb begin
    w_idx      = int'(row_sel) * COLS + int'(col_sel);
    w_in_range = (int'(row_sel) < ROWS) && (int'(col_sel) < COLS);
    w_mask     = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = w_in_range && (i == w_idx);
    end
    w_repeat   = 1'b0;
    w_invalid  = 1'b0;
    w_map_next = map_out;
    if (!mode) begin
      w_map_next = map_out | map_in;
    end else if (w_in_range) begin
      w_repeat   = |(map_out & w_mask);
      w_map_next = map_out | w_mask;
    end else begin
      w_invalid  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_btn_q      <= 1'b0;
      commit_ack   <= 1'b0;
      repeat_flag  <= 1'b0;
      invalid_addr <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_btn_q      <= btn;
      commit_ack   <= w_accept;
      repeat_flag  <= w_accept & w_repeat;
      invalid_addr <= w_accept & w_invalid;
    end
  end

  // Count and full are derived from the new map so they track it with no lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_out   <= '0;
      hit_count <= '0;
      full      <= 1'b0;
    end else if (w_accept) begin
      map_out   <= w_map_next;
      hit_count <= popcount(w_map_next);
      full      <= &w_map_next;
    end
  end

endmodule

// File: tb/tb_attack_history.sv
// Self-checking bench for attack_history: scoreboard of expected commit results
// on the default 7x5 map, plus a small 3x3 instance.
module tb_attack_history;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int N    = ROWS * COLS;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn, enable, mode;
  logic [N-1:0]  map_in;
  logic [2:0]    row_sel, col_sel;
  logic [N-1:0]  map_out;
  logic [5:0]    hit_count;
  logic          full, commit_ack, repeat_flag, invalid_addr;

  logic          s_btn, s_enable, s_mode;
  logic [8:0]    s_map_in;
  logic [1:0]    s_row_sel, s_col_sel;
  logic [8:0]    s_map_out;
  logic [3:0]    s_hit_count;
  logic          s_full, s_commit_ack, s_repeat_flag, s_invalid_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] map;
    logic [5:0]   cnt;
    logic         full;
    logic         rep;
    logic         inv;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [N-1:0] model_map;
  int           acks;

  attack_history u_dut (
    .clk(clk), .reset(reset), .btn(btn), .enable(enable), .mode(mode),
    .map_in(map_in), .row_sel(row_sel), .col_sel(col_sel),
    .map_out(map_out), .hit_count(hit_count), .full(full),
    .commit_ack(commit_ack), .repeat_flag(repeat_flag), .invalid_addr(invalid_addr)
  );

  attack_history #(.ROWS(3), .COLS(3)) u_small (
    .clk(clk), .reset(reset), .btn(s_btn), .enable(s_enable), .mode(s_mode),
    .map_in(s_map_in), .row_sel(s_row_sel), .col_sel(s_col_sel),
    .map_out(s_map_out), .hit_count(s_hit_count), .full(s_full),
    .commit_ack(s_commit_ack), .repeat_flag(s_repeat_flag), .invalid_addr(s_invalid_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [N+9:0] outs();
    return {map_out, hit_count, full, commit_ack, repeat_flag, invalid_addr};
  endfunction

  function automatic logic [N+9:0] want(input exp_t x);
    return {x.map, x.cnt, x.full, 1'b1, x.rep, x.inv};
  endfunction

  // Drive one press, record the expected result, and return once it is visible.
  task automatic press(input logic m, input logic [N-1:0] mi, input logic [2:0] r, input logic [2:0] c);
    exp_t x;
    @(negedge clk);
    btn = 1'b1; mode = m; map_in = mi; row_sel = r; col_sel = c;
    x.rep = 1'b0;
    x.inv = 1'b0;
    if (!m) begin
      model_map = model_map | mi;
    end else if (r >= 3'(ROWS) || c >= 3'(COLS)) begin
      x.inv = 1'b1;
    end else begin
      x.rep = model_map[int'(r) * COLS + int'(c)];
      model_map[int'(r) * COLS + int'(c)] = 1'b1;
    end
    x.map  = model_map;
    x.cnt  = 6'($countones(model_map));
    x.full = &model_map;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Release the button and scramble the commit inputs, which must now be ignored.
  task automatic release_btn();
    btn = 1'b0; mode = ~mode; map_in = ~map_in; row_sel = 3'd1; col_sel = 3'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 1'b0; enable = 1'b1; mode = 1'b0; map_in = '0;
    row_sel = 3'd0; col_sel = 3'd0;
    s_btn = 1'b0; s_enable = 1'b1; s_mode = 1'b0; s_map_in = 9'd0;
    s_row_sel = 2'd0; s_col_sel = 2'd0;
    model_map = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_state got %h want 0", outs()); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_release got %h want 0", outs()); end
  endtask

  task automatic test_bulk();
    press(1'b0, 35'h4_0000_0041, 3'd0, 3'd0);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL bulk got %h want %h", outs(), want(e)); end
    checks++;
    if (map_out !== 35'h4_0000_0041 || hit_count !== 6'd3) begin
      errors++; $display("FAIL bulk_bits got map=%h cnt=%0d want map=400000041 cnt=3", map_out, hit_count);
    end
    release_btn();
    checks++;
    if (commit_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %b want 0", commit_ack); end
  endtask

  task automatic test_sticky();
    press(1'b0, 35'h40, 3'd0, 3'd0);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL sticky_a got %h want %h", outs(), want(e)); end
    release_btn();
    press(1'b0, 35'h0, 3'd0, 3'd0);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL sticky_b got %h want %h", outs(), want(e)); end
    checks++;
    if (map_out !== 35'h4_0000_0041 || hit_count !== 6'd3) begin
      errors++; $display("FAIL sticky_bits got map=%h cnt=%0d want map=400000041 cnt=3", map_out, hit_count);
    end
    release_btn();
  endtask

  task automatic test_single();
    press(1'b1, '0, 3'd2, 3'd4);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL single got %h want %h", outs(), want(e)); end
    checks++;
    if (map_out[14] !== 1'b1 || hit_count !== 6'd4) begin
      errors++; $display("FAIL single_bit got bit14=%b cnt=%0d want bit14=1 cnt=4", map_out[14], hit_count);
    end
    release_btn();
    press(1'b1, '0, 3'd2, 3'd4);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL repeat got %h want %h", outs(), want(e)); end
    checks++;
    if (repeat_flag !== 1'b1 || hit_count !== 6'd4) begin
      errors++; $display("FAIL repeat_flag got rep=%b cnt=%0d want rep=1 cnt=4", repeat_flag, hit_count);
    end
    release_btn();
    checks++;
    if (repeat_flag !== 1'b0) begin errors++; $display("FAIL repeat_pulse got %b want 0", repeat_flag); end
  endtask

  task automatic test_invalid();
    press(1'b1, '0, 3'd7, 3'd0);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL invalid_row got %h want %h", outs(), want(e)); end
    release_btn();
    press(1'b1, '0, 3'd0, 3'd5);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL invalid_col got %h want %h", outs(), want(e)); end
    release_btn();
    @(negedge clk);
    btn = 1'b1; mode = 1'b1; row_sel = 3'd7; col_sel = 3'd0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (commit_ack === 1'b1) acks++;
    end
    release_btn();
    checks++;
    if (acks !== 1) begin errors++; $display("FAIL hold_acks got %0d want 1", acks); end
  endtask

  task automatic test_enable();
    @(negedge clk);
    enable = 1'b0; btn = 1'b1; mode = 1'b0; map_in = '1;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (commit_ack === 1'b1) acks++;
    end
    enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (commit_ack === 1'b1) acks++;
    end
    release_btn();
    checks++;
    if (acks !== 0 || map_out !== model_map) begin
      errors++; $display("FAIL enable_block got acks=%0d map=%h want acks=0 map=%h", acks, map_out, model_map);
    end
  endtask

  task automatic test_fill();
    int bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        press(1'b1, '0, 3'(r), 3'(c));
        e = sb.pop_front(); checks++;
        if (outs() !== want(e)) begin
          errors++; bad++;
          $display("FAIL fill r%0d c%0d got %h want %h", r, c, outs(), want(e));
        end
        release_btn();
      end
    end
    checks++;
    if (hit_count !== 6'd35 || full !== 1'b1) begin
      errors++; $display("FAIL fill_full got cnt=%0d full=%b want cnt=35 full=1", hit_count, full);
    end
    press(1'b0, '0, 3'd0, 3'd0);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e) || full !== 1'b1) begin
      errors++; $display("FAIL full_sticky got %h want %h", outs(), want(e));
    end
    release_btn();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    btn = 1'b1; mode = 1'b0; map_in = 35'd8;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL async_reset got %h want 0", outs()); end
    @(negedge clk);
    reset = 1'b0;
    model_map = 35'd8;
    e.map = 35'd8; e.cnt = 6'd1; e.full = 1'b0; e.rep = 1'b0; e.inv = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (outs() !== want(e)) begin errors++; $display("FAIL held_btn_after_reset got %h want %h", outs(), want(e)); end
    release_btn();
  endtask

  task automatic test_small();
    @(negedge clk);
    s_enable = 1'b0; s_btn = 1'b1; s_mode = 1'b0; s_map_in = 9'h1FF;
    @(negedge clk);
    checks++;
    if (s_commit_ack !== 1'b0 || s_map_out !== 9'h000) begin
      errors++; $display("FAIL small_enable got ack=%b map=%h want ack=0 map=000", s_commit_ack, s_map_out);
    end
    s_btn = 1'b0;
    @(negedge clk);
    s_enable = 1'b1; s_btn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_commit_ack !== 1'b1 || s_map_out !== 9'h1FF || s_hit_count !== 4'd9 || s_full !== 1'b1) begin
      errors++;
      $display("FAIL small_full got ack=%b map=%h cnt=%0d full=%b want ack=1 map=1ff cnt=9 full=1",
               s_commit_ack, s_map_out, s_hit_count, s_full);
    end
    s_btn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_bulk();
    test_sticky();
    test_single();
    test_invalid();
    test_enable();
    test_fill();
    test_async_reset();
    test_small();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
